systolic_seq_ctrl: RTL and testbench

- Sequencer for the ROW_len x COL_len output-stationary systolic MAC array.
- Accepts one A column and one B row per beat, clears the array accumulators, and skews operands onto the array's a_bus/b_bus (row i delayed i cycles, column j delayed j).
- Counts K beats plus the drain time, captures the array's c_bus into an output register, and hands the result off with valid/ready.
- Sits between the operand buffer/DMA and the PE array.

---
 rtl/systolic_seq_ctrl_pkg.sv | 22 ++
 rtl/systolic_seq_ctrl_skew_line.sv | 35 +++
 rtl/systolic_seq_ctrl.sv | 159 +++++++++++++++
 tb/tb_systolic_seq_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_seq_ctrl_pkg.sv
// Shared types and helpers for the systolic array sequencer: FSM state encoding,
// drain-length rule and the flat C-bus index used to address PE(i,j) results.
package systolic_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLEAR = 3'd1,
      S_FEED  = 3'd2,
      S_DRAIN = 3'd3,
      S_HOLD  = 3'd4
   } state_t;

   // Cycles for the last operand to cross the array and land in PE(R-1,C-1).
   function automatic int drain_len(input int rows, input int cols);
      return rows + cols - 1;
   endfunction

   function automatic int cbus_idx(input int row, input int col, input int cols);
      return row * cols + col;
   endfunction

endpackage

// File: rtl/systolic_seq_ctrl_skew_line.sv
// Zero-reset delay line of DEPTH stages with a synchronous flush; DEPTH=0 is a
// plain wire.
module skew_line #(
   parameter int W     = 8,
   parameter int DEPTH = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_clr,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);

   if (DEPTH == 0) begin : g_wire
      logic w_unused_ok;
      assign w_unused_ok = clk ^ rst_n ^ i_clr;
      assign o_q = i_d;
   end else begin : g_sr
      logic [W-1:0] r_sr [DEPTH];

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) r_sr[k] <= '0;
         end else if (i_clr) begin
            for (int k = 0; k < DEPTH; k++) r_sr[k] <= '0;
         end else begin
            r_sr[0] <= i_d;
            for (int k = 1; k < DEPTH; k++) r_sr[k] <= r_sr[k-1];
         end
      end

      assign o_q = r_sr[DEPTH-1];
   end

endmodule

// File: rtl/systolic_seq_ctrl.sv
// Sequencer for an output-stationary systolic MAC array: clears, feeds skewed
// operands, drains and hands off the result. SYSTOLIC_SEQ_PERF_EN adds stall_cnt.
module systolic_seq_ctrl
   import systolic_pkg::*;
#(
   parameter int ROW_len = 3,
   parameter int COL_len = 3,
   parameter int DW      = 8,
   parameter int ACCW    = 16,
   parameter int KW      = 8
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             start,
   input  logic [KW-1:0]                    k_len,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [ROW_len*DW-1:0]            a_col,
   input  logic [COL_len*DW-1:0]            b_row,
   output logic [ROW_len*DW-1:0]            a_bus,
   output logic [COL_len*DW-1:0]            b_bus,
   output logic                             arr_clr_n,
   input  logic [ROW_len*COL_len*ACCW-1:0]  c_bus,
   output logic [ROW_len*COL_len*ACCW-1:0]  c_out,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic                             busy,
`ifdef SYSTOLIC_SEQ_PERF_EN
   output logic [15:0]                      stall_cnt,
`endif
   output logic                             done
);

   localparam int D_LEN = drain_len(ROW_len, COL_len);
   localparam int DCW   = $clog2(D_LEN + 1);

   state_t                         r_state, w_next;
   logic [KW-1:0]                  r_k_rem;
   logic [DCW-1:0]                 r_d_cnt;
   logic                           r_clr_n;
   logic [ROW_len*COL_len*ACCW-1:0] r_c_out;
   logic [ROW_len*DW-1:0]          r_a_bus, w_push_a, w_skew_a;
   logic [COL_len*DW-1:0]          r_b_bus, w_push_b, w_skew_b;
   logic                           w_beat, w_capture, w_done, w_flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      w_beat    = 1'b0;
      w_capture = 1'b0;
      w_done    = 1'b0;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = (r_state != S_IDLE);
      w_flush   = (r_state == S_CLEAR);
      case (r_state)
         S_IDLE:  if (start) w_next = S_CLEAR;
         S_CLEAR: w_next = (r_k_rem == '0) ? S_DRAIN : S_FEED;
         S_FEED: begin
            in_ready = 1'b1;
            if (in_valid) begin
               w_beat = 1'b1;
               if (r_k_rem == KW'(1)) w_next = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (r_d_cnt == '0) begin
               w_capture = 1'b1;
               w_next    = S_HOLD;
            end
         end
         S_HOLD: begin
            out_valid = 1'b1;
            if (out_ready) begin
               w_done = 1'b1;
               w_next = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_k_rem <= '0;
         r_d_cnt <= '0;
         r_clr_n <= 1'b1;
         r_c_out <= '0;
      end else begin
         if (r_state == S_IDLE && start) r_k_rem <= k_len;
         else if (w_beat)                r_k_rem <= r_k_rem - KW'(1);
         if (w_next == S_DRAIN && r_state != S_DRAIN) r_d_cnt <= DCW'(D_LEN - 1);
         else if (r_state == S_DRAIN && r_d_cnt != '0) r_d_cnt <= r_d_cnt - DCW'(1);
         // Registered from next state so the clear is low exactly during CLEAR.
         r_clr_n <= (w_next != S_CLEAR);
         if (w_capture) r_c_out <= c_bus;
      end
   end

   // Bubbles push zeros so A and B slip together and add nothing.
   assign w_push_a = w_beat ? a_col : '0;
   assign w_push_b = w_beat ? b_row : '0;

   for (genvar gi = 0; gi < ROW_len; gi++) begin : g_row
      skew_line #(.W(DW), .DEPTH(gi)) u_skew (
         .clk   (clk),
         .rst_n (rst_n),
         .i_clr (w_flush),
         .i_d   (w_push_a[gi*DW +: DW]),
         .o_q   (w_skew_a[gi*DW +: DW])
      );
   end

   for (genvar gj = 0; gj < COL_len; gj++) begin : g_col
      skew_line #(.W(DW), .DEPTH(gj)) u_skew (
         .clk   (clk),
         .rst_n (rst_n),
         .i_clr (w_flush),
         .i_d   (w_push_b[gj*DW +: DW]),
         .o_q   (w_skew_b[gj*DW +: DW])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a_bus <= '0;
         r_b_bus <= '0;
      end else if (w_flush) begin
         r_a_bus <= '0;
         r_b_bus <= '0;
      end else begin
         r_a_bus <= w_skew_a;
         r_b_bus <= w_skew_b;
      end
   end

`ifdef SYSTOLIC_SEQ_PERF_EN
   logic [15:0] r_stall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                         r_stall <= '0;
      else if (r_state == S_CLEAR)                        r_stall <= '0;
      else if (r_state == S_FEED && !in_valid && r_stall != 16'hFFFF) r_stall <= r_stall + 16'd1;
   end

   assign stall_cnt = r_stall;
`endif

   assign a_bus     = r_a_bus;
   assign b_bus     = r_b_bus;
   assign arr_clr_n = r_clr_n;
   assign c_out     = r_c_out;
   assign done      = w_done;

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Bench for systolic_seq_ctrl: behavioural 3x3 systolic array around the DUT,
// table vectors, corner sequences and random jobs checked by a matrix model.
module tb_systolic_seq_ctrl;
   import systolic_pkg::*;

   localparam int R    = 3;
   localparam int C    = 3;
   localparam int DW   = 8;
   localparam int ACCW = 16;
   localparam int KW   = 8;
   localparam int CW   = R * C * ACCW;

   typedef logic [CW-1:0]   wide_t;
   typedef logic [R*DW-1:0] acol_t;
   typedef logic [C*DW-1:0] brow_t;

   typedef struct packed {
      logic [7:0]             k;
      logic [3:0][R*DW-1:0]   a;
      logic [3:0][C*DW-1:0]   b;
      logic [CW-1:0]          c;
      logic [7:0]             lat;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst_n, start, in_valid, in_ready, arr_clr_n, out_valid, out_ready, busy, done;
   logic [KW-1:0] k_len;
   acol_t         a_col, a_bus;
   brow_t         b_row, b_bus;
   wide_t         c_bus, c_out;
`ifdef SYSTOLIC_SEQ_PERF_EN
   logic [15:0]   stall_cnt;
`endif

   int n_chk = 0;
   int n_err = 0;

   acol_t ja [16];
   brow_t jb [16];
   int    jst[16];
   vec_t  tbl[5];

   always #5 clk = ~clk;

   systolic_seq_ctrl #(
      .ROW_len(R), .COL_len(C), .DW(DW), .ACCW(ACCW), .KW(KW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .k_len     (k_len),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a_col     (a_col),
      .b_row     (b_row),
      .a_bus     (a_bus),
      .b_bus     (b_bus),
      .arr_clr_n (arr_clr_n),
      .c_bus     (c_bus),
      .c_out     (c_out),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy),
`ifdef SYSTOLIC_SEQ_PERF_EN
      .stall_cnt (stall_cnt),
`endif
      .done      (done)
   );

   // Output-stationary array: A moves right, B moves down, one register per hop.
   // Each PE exposes acc + current product so the final term is visible on c_bus.
   logic signed [DW-1:0]   m_ain[R][C], m_bin[R][C], m_ap[R][C], m_bp[R][C];
   logic signed [ACCW-1:0] m_acc[R][C];

   always_comb begin
      c_bus = '0;
      for (int i = 0; i < R; i++) begin
         for (int j = 0; j < C; j++) begin
            if (j == 0) m_ain[i][j] = a_bus[i*DW +: DW];
            else        m_ain[i][j] = m_ap[i][j-1];
            if (i == 0) m_bin[i][j] = b_bus[j*DW +: DW];
            else        m_bin[i][j] = m_bp[i-1][j];
            c_bus[cbus_idx(i, j, C)*ACCW +: ACCW] = m_acc[i][j] + ACCW'(m_ain[i][j]) * ACCW'(m_bin[i][j]);
         end
      end
   end

   always @(posedge clk or negedge rst_n) begin
      for (int i = 0; i < R; i++) begin
         for (int j = 0; j < C; j++) begin
            if (!rst_n || !arr_clr_n) begin
               m_acc[i][j] <= '0;
               m_ap[i][j]  <= '0;
               m_bp[i][j]  <= '0;
            end else begin
               m_acc[i][j] <= m_acc[i][j] + ACCW'(m_ain[i][j]) * ACCW'(m_bin[i][j]);
               m_ap[i][j]  <= m_ain[i][j];
               m_bp[i][j]  <= m_bin[i][j];
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input wide_t act, input wide_t exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // C = A*B over the first k beats, wrapped to ACCW bits.
   function automatic wide_t ref_c(input int k);
      wide_t                  r;
      logic signed [ACCW-1:0] s;
      logic signed [DW-1:0]   av, bv;
      r = '0;
      for (int i = 0; i < R; i++) begin
         for (int j = 0; j < C; j++) begin
            s = '0;
            for (int b = 0; b < k; b++) begin
               av = ja[b][i*DW +: DW];
               bv = jb[b][j*DW +: DW];
               s  = s + ACCW'(av) * ACCW'(bv);
            end
            r[(i*C + j)*ACCW +: ACCW] = s;
         end
      end
      return r;
   endfunction

   task automatic run_job(input int k, input int hold, input bit use_tbl,
                          input wide_t tc, input int tlat, output int lat_o);
      wide_t expc;
      int    explat, n, b, bl, stalls;
      logic  took;
      stalls = 0;
      for (int x = 0; x < k; x++) stalls += jst[x];
      expc   = use_tbl ? tc : ref_c(k);
      explat = use_tbl ? tlat : (1 + k + stalls + (R + C - 1) + 1);
      chk("idle_busy", wide_t'(busy), wide_t'(0));
      start = 1'b1;
      k_len = KW'(k);
      tick();
      start = 1'b0;
      n     = 1;
      chk("clear_clr_n", wide_t'(arr_clr_n), wide_t'(0));
      chk("clear_busy", wide_t'(busy), wide_t'(1));
      chk("clear_in_ready", wide_t'(in_ready), wide_t'(0));
      b  = 0;
      bl = (k > 0) ? jst[0] : 0;
      while (!out_valid && n < 300) begin
         if (n == 2) chk("clr_n_release", wide_t'(arr_clr_n), wide_t'(1));
         if (b < k && !(in_ready && bl > 0)) begin
            in_valid = 1'b1;
            a_col    = ja[b];
            b_row    = jb[b];
         end else begin
            in_valid = 1'b0;
            a_col    = acol_t'($urandom);
            b_row    = brow_t'($urandom);
            if (b < k && in_ready) bl--;
         end
         took = in_valid && in_ready;
         tick();
         n++;
         if (took) begin
            b++;
            bl = (b < k) ? jst[b] : 0;
         end
      end
      in_valid = 1'b0;
      lat_o    = n;
      chk("out_valid", wide_t'(out_valid), wide_t'(1));
      chk("latency", wide_t'(n), wide_t'(explat));
      chk("beats", wide_t'(b), wide_t'(k));
      chk("in_ready_drop", wide_t'(in_ready), wide_t'(0));
      chk("c_out", c_out, expc);
`ifdef SYSTOLIC_SEQ_PERF_EN
      chk("stall_cnt", wide_t'(stall_cnt), wide_t'(stalls));
`endif
      for (int h = 0; h < hold; h++) begin
         out_ready = 1'b0;
         start     = h[0];
         tick();
         chk("hold_valid", wide_t'(out_valid), wide_t'(1));
         chk("hold_c_out", c_out, expc);
         chk("hold_done", wide_t'(done), wide_t'(0));
      end
      out_ready = 1'b1;
      start     = 1'b1;
      #1;
      chk("handshake_done", wide_t'(done), wide_t'(1));
      tick();
      out_ready = 1'b0;
      start     = 1'b0;
      chk("post_valid", wide_t'(out_valid), wide_t'(0));
      chk("post_done", wide_t'(done), wide_t'(0));
      chk("post_busy", wide_t'(busy), wide_t'(0));
      tick();
      chk("start_ignored", wide_t'(busy), wide_t'(0));
   endtask

   task automatic load_tbl(input int t);
      for (int b = 0; b < 4; b++) begin
         ja[b]  = tbl[t].a[b];
         jb[b]  = tbl[t].b[b];
         jst[b] = 0;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat1, lat2, k, hold;

      // A=I, B=1..9
      tbl[0] = '{k: 8'd3,
                 a: {24'h000000, 24'h010000, 24'h000100, 24'h000001},
                 b: {24'h000000, 24'h090807, 24'h060504, 24'h030201},
                 c: {16'd9, 16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1},
                 lat: 8'd10};
      tbl[1] = '{k: 8'd0, a: '0, b: '0, c: '0, lat: 8'd7};
      // -128 * -128 twice wraps to 16'h8000
      tbl[2] = '{k: 8'd2,
                 a: {24'h0, 24'h0, 24'h808080, 24'h808080},
                 b: {24'h0, 24'h0, 24'h808080, 24'h808080},
                 c: {9{16'h8000}},
                 lat: 8'd9};
      // Outer product [1,2,3]' x [4,5,6]
      tbl[3] = '{k: 8'd1,
                 a: {24'h0, 24'h0, 24'h0, 24'h030201},
                 b: {24'h0, 24'h0, 24'h0, 24'h060504},
                 c: {16'd18, 16'd15, 16'd12, 16'd12, 16'd10, 16'd8, 16'd6, 16'd5, 16'd4},
                 lat: 8'd8};
      // Mixed signs: A cols [-1,2,-3],[4,0,-2]; B rows [5,-6,7],[1,1,-1]
      tbl[4] = '{k: 8'd2,
                 a: {24'h0, 24'h0, 24'hFE0004, 24'hFD02FF},
                 b: {24'h0, 24'h0, 24'hFF0101, 24'h07FA05},
                 c: {16'hFFED, 16'h0010, 16'hFFEF, 16'h000E, 16'hFFF4,
                     16'h000A, 16'hFFF5, 16'h000A, 16'hFFFF},
                 lat: 8'd9};

      rst_n     = 1'b0;
      start     = 1'b0;
      k_len     = '0;
      in_valid  = 1'b0;
      a_col     = '0;
      b_row     = '0;
      out_ready = 1'b0;
      for (int b = 0; b < 16; b++) jst[b] = 0;
      tick();
      tick();
      chk("rst_a_bus", wide_t'(a_bus), wide_t'(0));
      chk("rst_b_bus", wide_t'(b_bus), wide_t'(0));
      chk("rst_clr_n", wide_t'(arr_clr_n), wide_t'(1));
      chk("rst_c_out", c_out, wide_t'(0));
      chk("rst_valid", wide_t'(out_valid), wide_t'(0));
      chk("rst_in_ready", wide_t'(in_ready), wide_t'(0));
      chk("rst_busy", wide_t'(busy), wide_t'(0));
      chk("rst_done", wide_t'(done), wide_t'(0));
      rst_n = 1'b1;
      tick();

      for (int t = 0; t < 5; t++) begin
         load_tbl(t);
         run_job(int'(tbl[t].k), t, 1'b1, tbl[t].c, int'(tbl[t].lat), lat1);
      end

      // Same K=4 job with and without bubbles before beats 2 and 3.
      for (int b = 0; b < 4; b++) begin
         ja[b]  = acol_t'($urandom);
         jb[b]  = brow_t'($urandom);
         jst[b] = 0;
      end
      run_job(4, 0, 1'b0, '0, 0, lat1);
      jst[1] = 2;
      jst[2] = 2;
      run_job(4, 0, 1'b0, '0, 0, lat2);
      chk("stall_delta", wide_t'(lat2 - lat1), wide_t'(4));

      // Long hold with start pulses, then a clean job right after release.
      load_tbl(0);
      run_job(3, 5, 1'b1, tbl[0].c, 10, lat1);
      load_tbl(4);
      run_job(2, 0, 1'b1, tbl[4].c, 9, lat1);

      // Reset while beat 2 of 4 is on the inputs.
      for (int b = 0; b < 4; b++) begin
         ja[b]  = acol_t'($urandom);
         jb[b]  = brow_t'($urandom);
         jst[b] = 0;
      end
      start = 1'b1;
      k_len = KW'(4);
      tick();
      start    = 1'b0;
      in_valid = 1'b1;
      a_col    = ja[0];
      b_row    = jb[0];
      tick();
      tick();
      a_col = ja[1];
      b_row = jb[1];
      chk("mid_in_ready", wide_t'(in_ready), wide_t'(1));
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_a_bus", wide_t'(a_bus), wide_t'(0));
      chk("mid_b_bus", wide_t'(b_bus), wide_t'(0));
      chk("mid_clr_n", wide_t'(arr_clr_n), wide_t'(1));
      chk("mid_c_out", c_out, wide_t'(0));
      chk("mid_valid", wide_t'(out_valid), wide_t'(0));
      chk("mid_in_ready_rst", wide_t'(in_ready), wide_t'(0));
      chk("mid_busy", wide_t'(busy), wide_t'(0));
      chk("mid_done", wide_t'(done), wide_t'(0));
      in_valid = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      load_tbl(3);
      run_job(1, 1, 1'b1, tbl[3].c, 8, lat1);

      for (int r = 0; r < 20; r++) begin
         k    = $urandom_range(0, 6);
         hold = $urandom_range(0, 3);
         for (int b = 0; b < 16; b++) begin
            ja[b]  = acol_t'($urandom);
            jb[b]  = brow_t'($urandom);
            jst[b] = $urandom_range(0, 2);
         end
         run_job(k, hold, 1'b0, '0, 0, lat1);
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
